// File: rtl/irq_csr_controller.sv
// irq_csr_controller: machine-mode interrupt CSR file (mstatus/mie/mtvec/mscratch/mepc/mcause/mip); optional mcycle/mcycleh counter under CSR_MCYCLE_EN
module irq_csr_controller #(
  parameter int IRQ_NUM = 16,
  parameter int XLEN = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [2:0]         opcode_i,
  input  logic [11:0]        addr_i,
  input  logic [XLEN-1:0]    rs1_data_i,
  input  logic [XLEN-1:0]    imm_data_i,
  input  logic               write_enable_i,
  input  logic               trap_i,
  input  logic [31:0]        pc_i,
  input  logic [31:0]        mcause_i,
  input  logic               mret_i,
  input  logic [IRQ_NUM-1:0] irq_i,
  output logic [XLEN-1:0]    read_data_o,
  output logic [31:0]        mie_o,
  output logic [31:0]        mepc_o,
  output logic [31:0]        mtvec_o,
  output logic               irq_req_o,
  output logic [31:0]        irq_cause_o
);
  logic               st_mie, st_mpie;
  logic [IRQ_NUM-1:0] mie_q, mip_q, pend;
  logic [31:0]        mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [31:0]        mie_w, mip_w, mstatus_w, src, wdata, rdata;
  logic               wr;
`ifdef CSR_MCYCLE_EN
  logic [63:0]        cyc_q, cyc_inc;
`endif
  assign mie_w = 32'(mie_q) << 16;
  assign mip_w = 32'(mip_q) << 16;
  assign mstatus_w = {24'b0, st_mpie, 3'b0, st_mie, 3'b0};
  assign src = opcode_i[2] ? imm_data_i : rs1_data_i;
  assign wr = write_enable_i && opcode_i[1:0] != 2'b00;
  assign wdata = opcode_i[1:0] == 2'b01 ? src : opcode_i[1:0] == 2'b10 ? (src | rdata) : (~src & rdata);
  always_comb begin
    rdata = '0;
    case (addr_i)
      12'h300: rdata = mstatus_w;
      12'h304: rdata = mie_w;
      12'h305: rdata = mtvec_q;
      12'h340: rdata = mscratch_q;
      12'h341: rdata = mepc_q;
      12'h342: rdata = mcause_q;
      12'h344: rdata = mip_w;
`ifdef CSR_MCYCLE_EN
      12'hB00: rdata = cyc_q[31:0];
      12'hB80: rdata = cyc_q[63:32];
`endif
      default: rdata = '0;
    endcase
  end
  assign read_data_o = rdata;
  assign pend = mip_q & mie_q;
  assign irq_req_o = st_mie && |pend;
  always_comb begin
    irq_cause_o = '0;
    for (int k = IRQ_NUM - 1; k >= 0; k--)
      if (pend[k]) irq_cause_o = {1'b1, 31'(16 + k)};
  end
  assign mie_o = mie_w;
  assign mepc_o = mepc_q;
  assign mtvec_o = mtvec_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_mie <= 1'b0;
      st_mpie <= 1'b0;
      mie_q <= '0;
      mip_q <= '0;
      mtvec_q <= '0;
      mscratch_q <= '0;
      mepc_q <= '0;
      mcause_q <= '0;
    end else begin
      mip_q <= irq_i;
      if (trap_i) begin
        st_mpie <= st_mie;
        st_mie <= 1'b0;
      end else if (mret_i) begin
        st_mie <= st_mpie;
        st_mpie <= 1'b1;
      end else if (wr && addr_i == 12'h300) begin
        st_mie <= wdata[3];
        st_mpie <= wdata[7];
      end
      if (trap_i) begin
        mepc_q <= pc_i & ~32'h3;
        mcause_q <= mcause_i;
      end else begin
        if (wr && addr_i == 12'h341) mepc_q <= wdata & ~32'h3;
        if (wr && addr_i == 12'h342) mcause_q <= wdata;
      end
      if (wr && addr_i == 12'h304) mie_q <= wdata[16 +: IRQ_NUM];
      if (wr && addr_i == 12'h305) mtvec_q <= wdata;
      if (wr && addr_i == 12'h340) mscratch_q <= wdata;
    end
  end
`ifdef CSR_MCYCLE_EN
  assign cyc_inc = cyc_q + 64'd1;
  always_ff @(posedge clk_i) begin
    if (rst_i) cyc_q <= '0;
    else begin
      cyc_q[31:0] <= (wr && addr_i == 12'hB00) ? wdata : cyc_inc[31:0];
      cyc_q[63:32] <= (wr && addr_i == 12'hB80) ? wdata : (wr && addr_i == 12'hB00) ? cyc_q[63:32] : cyc_inc[63:32];
    end
  end
`endif
endmodule

// File: tb/tb_irq_csr_controller.sv
// tb_irq_csr_controller: directed self-checking bench for irq_csr_controller
module tb_irq_csr_controller;
  localparam logic [2:0] RW = 3'b001, RS = 3'b010, RC = 3'b011, RWI = 3'b101, RSI = 3'b110, RCI = 3'b111;
  logic        clk_i = 0, rst_i = 0;
  logic [2:0]  opcode_i = 0;
  logic [11:0] addr_i = 0;
  logic [31:0] rs1_data_i = 0, imm_data_i = 0, pc_i = 0, mcause_i = 0;
  logic        write_enable_i = 0, trap_i = 0, mret_i = 0;
  logic [15:0] irq_i = 0;
  logic [31:0] read_data_o, mie_o, mepc_o, mtvec_o, irq_cause_o;
  logic        irq_req_o;
  int checks = 0, errors = 0;
  logic [31:0] v;
  irq_csr_controller dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .addr_i(addr_i),
    .rs1_data_i(rs1_data_i), .imm_data_i(imm_data_i), .write_enable_i(write_enable_i),
    .trap_i(trap_i), .pc_i(pc_i), .mcause_i(mcause_i), .mret_i(mret_i), .irq_i(irq_i),
    .read_data_o(read_data_o), .mie_o(mie_o), .mepc_o(mepc_o), .mtvec_o(mtvec_o),
    .irq_req_o(irq_req_o), .irq_cause_o(irq_cause_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic set_op(input logic [2:0] op, input logic [11:0] a, input logic [31:0] s);
    opcode_i = op;
    addr_i = a;
    rs1_data_i = op[2] ? 32'hDEAD_BEEF : s;
    imm_data_i = op[2] ? s : 32'hDEAD_BEEF;
    write_enable_i = 1;
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
    write_enable_i = 0;
    trap_i = 0;
    mret_i = 0;
  endtask
  task automatic csr(input logic [2:0] op, input logic [11:0] a, input logic [31:0] s);
    set_op(op, a, s);
    step();
  endtask
  task automatic rd(input logic [11:0] a, output logic [31:0] r);
    write_enable_i = 0;
    addr_i = a;
    #1;
    r = read_data_o;
  endtask
  task automatic test_reset();
    rst_i = 1;
    irq_i = 16'hFFFF;
    trap_i = 1;
    pc_i = 32'h400;
    mcause_i = 32'h8000_0010;
    set_op(RW, 12'h305, 32'h55);
    step();
    checks++; if (mtvec_o !== 0) begin errors++; $display("FAIL reset_mtvec: got %h expected 0", mtvec_o); end
    checks++; if (mepc_o !== 0) begin errors++; $display("FAIL reset_mepc: got %h expected 0", mepc_o); end
    checks++; if (mie_o !== 0) begin errors++; $display("FAIL reset_mie: got %h expected 0", mie_o); end
    checks++; if (irq_req_o !== 0 || irq_cause_o !== 0) begin errors++; $display("FAIL reset_irq: got req %b cause %h expected 0/0", irq_req_o, irq_cause_o); end
    rd(12'h300, v);
    checks++; if (v !== 0) begin errors++; $display("FAIL reset_mstatus: got %h expected 0", v); end
    rd(12'h344, v);
    checks++; if (v !== 0) begin errors++; $display("FAIL reset_mip: got %h expected 0", v); end
    rst_i = 0;
    step();
    checks++; if (mtvec_o !== 0 || mepc_o !== 0 || mie_o !== 0 || irq_req_o !== 0 || irq_cause_o !== 0) begin errors++; $display("FAIL post_reset: got mtvec %h mepc %h mie %h req %b cause %h expected all 0", mtvec_o, mepc_o, mie_o, irq_req_o, irq_cause_o); end
    irq_i = 0;
    step();
  endtask
  task automatic test_mtvec();
    csr(RW, 12'h305, 32'h0000_0100);
    checks++; if (mtvec_o !== 32'h100) begin errors++; $display("FAIL mtvec_rw: got %h expected 100", mtvec_o); end
    rd(12'h305, v);
    checks++; if (v !== 32'h100) begin errors++; $display("FAIL mtvec_read: got %h expected 100", v); end
    csr(RS, 12'h305, 32'h3);
    checks++; if (mtvec_o !== 32'h103) begin errors++; $display("FAIL mtvec_rs: got %h expected 103", mtvec_o); end
    csr(RCI, 12'h305, 32'h1);
    checks++; if (mtvec_o !== 32'h102) begin errors++; $display("FAIL mtvec_rci: got %h expected 102", mtvec_o); end
    csr(RW, 12'h340, 32'hCAFE_0001);
    rd(12'h340, v);
    checks++; if (v !== 32'hCAFE_0001) begin errors++; $display("FAIL mscratch: got %h expected cafe0001", v); end
  endtask
  task automatic test_masks();
    csr(RW, 12'h300, 32'hFFFF_FFFF);
    rd(12'h300, v);
    checks++; if (v !== 32'h88) begin errors++; $display("FAIL mstatus_mask: got %h expected 88", v); end
    csr(RW, 12'h304, 32'hFFFF_FFFF);
    checks++; if (mie_o !== 32'hFFFF_0000) begin errors++; $display("FAIL mie_mask: got %h expected ffff0000", mie_o); end
    csr(RW, 12'h341, 32'h207);
    checks++; if (mepc_o !== 32'h204) begin errors++; $display("FAIL mepc_align: got %h expected 204", mepc_o); end
    csr(RW, 12'h123, 32'hFFFF);
    rd(12'h123, v);
    checks++; if (v !== 0) begin errors++; $display("FAIL unimpl: got %h expected 0", v); end
  endtask
  task automatic test_irq();
    csr(RW, 12'h304, 32'h0001_0000);
    csr(RWI, 12'h300, 32'h8);
    rd(12'h300, v);
    checks++; if (v !== 32'h8) begin errors++; $display("FAIL mstatus_rwi: got %h expected 8", v); end
    irq_i = 16'h0001;
    #1;
    checks++; if (irq_req_o !== 0) begin errors++; $display("FAIL irq_latency: got req %b expected 0", irq_req_o); end
    step();
    checks++; if (irq_req_o !== 1 || irq_cause_o !== 32'h8000_0010) begin errors++; $display("FAIL irq0: got req %b cause %h expected 1/80000010", irq_req_o, irq_cause_o); end
  endtask
  task automatic test_trap();
    trap_i = 1;
    pc_i = 32'h200;
    mcause_i = 32'h8000_0010;
    step();
    checks++; if (mepc_o !== 32'h200) begin errors++; $display("FAIL trap_mepc: got %h expected 200", mepc_o); end
    rd(12'h342, v);
    checks++; if (v !== 32'h8000_0010) begin errors++; $display("FAIL trap_mcause: got %h expected 80000010", v); end
    rd(12'h300, v);
    checks++; if (v !== 32'h80) begin errors++; $display("FAIL trap_mstatus: got %h expected 80", v); end
    checks++; if (irq_req_o !== 0) begin errors++; $display("FAIL trap_req: got %b expected 0", irq_req_o); end
    mret_i = 1;
    step();
    rd(12'h300, v);
    checks++; if (v !== 32'h88) begin errors++; $display("FAIL mret_mstatus: got %h expected 88", v); end
  endtask
  task automatic test_priority();
    trap_i = 1;
    pc_i = 32'h304;
    set_op(RW, 12'h305, 32'h400);
    step();
    checks++; if (mtvec_o !== 32'h400 || mepc_o !== 32'h304) begin errors++; $display("FAIL trap_with_mtvec: got mtvec %h mepc %h expected 400/304", mtvec_o, mepc_o); end
    trap_i = 1;
    pc_i = 32'h300;
    set_op(RW, 12'h341, 32'h44);
    step();
    checks++; if (mepc_o !== 32'h300) begin errors++; $display("FAIL trap_over_mepc: got %h expected 300", mepc_o); end
    mret_i = 1;
    set_op(RW, 12'h300, 32'h0);
    step();
    rd(12'h300, v);
    checks++; if (v !== 32'h80) begin errors++; $display("FAIL mret_over_write: got %h expected 80", v); end
    rd(12'h344, v);
    checks++; if (v !== 32'h0001_0000) begin errors++; $display("FAIL mip_before: got %h expected 10000", v); end
    csr(RSI, 12'h344, 32'h1F);
    rd(12'h344, v);
    checks++; if (v !== 32'h0001_0000) begin errors++; $display("FAIL mip_readonly: got %h expected 10000", v); end
  endtask
  task automatic test_cause_select();
    csr(RSI, 12'h300, 32'h8);
    irq_i = 16'h000A;
    csr(RW, 12'h304, 32'h000A_0000);
    checks++; if (irq_req_o !== 1 || irq_cause_o !== 32'h8000_0011) begin errors++; $display("FAIL cause_lowest: got req %b cause %h expected 1/80000011", irq_req_o, irq_cause_o); end
    csr(RC, 12'h304, 32'h0002_0000);
    checks++; if (irq_cause_o !== 32'h8000_0013 || mie_o !== 32'h0008_0000) begin errors++; $display("FAIL cause_after_rc: got cause %h mie %h expected 80000013/80000", irq_cause_o, mie_o); end
    csr(RCI, 12'h300, 32'h8);
    checks++; if (irq_req_o !== 0 || irq_cause_o !== 32'h8000_0013) begin errors++; $display("FAIL mie_gate: got req %b cause %h expected 0/80000013", irq_req_o, irq_cause_o); end
  endtask
  task automatic test_mcycle();
`ifdef CSR_MCYCLE_EN
    csr(RW, 12'hB80, 32'h0);
    csr(RW, 12'hB00, 32'hFFFF_FFFF);
    step();
    rd(12'hB80, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL mcycleh_carry: got %h expected 1", v); end
    rd(12'hB00, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL mcycle_wrap: got %h expected 0", v); end
`else
    csr(RW, 12'hB00, 32'h5);
    rd(12'hB00, v);
    checks++; if (v !== 0) begin errors++; $display("FAIL mcycle_absent: got %h expected 0", v); end
    rd(12'hB80, v);
    checks++; if (v !== 0) begin errors++; $display("FAIL mcycleh_absent: got %h expected 0", v); end
`endif
  endtask
  initial begin
    test_reset();
    test_mtvec();
    test_masks();
    test_irq();
    test_trap();
    test_priority();
    test_cause_select();
    test_mcycle();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
